nucleo_rpn_param: RTL and testbench
===================================

// Module: nucleo_rpn_param
// PURPOSE
//  Parametrised, clocked RPN core: operand stack plus ALU plus control FSM in one block.
//  Successor to the fixed 8-bit calculator datapath; WIDTH and DEPTH are generic.
//  Adds real push/pop semantics, underflow/overflow detection and a busy/done handshake.
//  Sits between the board I/O decoding (SW/KEY edge-detect) and base conversion/7-seg display.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=4)
//  DEPTH  4  stack entries (>=2); PW = $clog2(DEPTH+1)
// PORTS
//  CLOCK_50     in   1      single system clock
//  reset        in   1      synchronous, active-high reset
//  limpar       in   1      synchronous stack clear (1-cycle strobe)
//  empilhar     in   1      push strobe; captures entrada
//  entrada      in   WIDTH  operand to push
//  executar     in   1      operation strobe; captures operacao
//  operacao     in   3      opcode (see rpn_pkg)
//  ocupado      out  1      FSM not in OCIOSO
//  pronto       out  1      1-cycle pulse when result written to top
//  topo         out  WIDTH  stack top (0 when empty)
//  segundo      out  WIDTH  entry below top (0 when depth<2)
//  profundidade out  PW     current entry count
//  zero, carry_out, overflow  out 1 each  flags of last completed op
//  erro         out  1      1-cycle pulse on rejected command
//  erro_codigo  out  3      cause, held until next erro: 0 none,1 cheia,2 vazia,3 ilegal,4 ocupado
// BEHAVIOUR
//  - Reset: stack empty, profundidade=0, all outputs 0, FSM=OCIOSO. Mid-operation reset aborts, nothing written.
//  - Priority each cycle: reset > limpar > executar > empilhar.
//  - limpar: profundidade<=0, flags<=0, FSM<=OCIOSO; erro_codigo unchanged.
//  - empilhar in OCIOSO: depth<DEPTH -> push next cycle; depth==DEPTH -> no change, erro, code 1.
//  - empilhar and executar same cycle: op accepted, push dropped, erro, code 4.
//  - Any strobe while ocupado: ignored, erro, code 4.
//  - FSM: OCIOSO -(executar, legal)-> BUSCA -> CALCULA -> ESCREVE -> OCIOSO.
//    BUSCA registers A=segundo, B=topo; CALCULA registers ALU result + flags;
//    ESCREVE updates stack and pulses pronto. Latency: strobe at cycle n -> pronto at n+3.
//  - Opcodes: 000 SOMA A+B, 001 SUB A-B, 010 AND, 011 OR, 100 XOR (binary: pop 2, push 1);
//    101 NOT ~B (unary: replace top); 110 DUP (push copy of B);
//    111 MUL low WIDTH bits of A*B (binary), only with RPN_MUL_EN.
//  - Precheck in OCIOSO, no state change on failure:
//    binary with depth<2 or unary/DUP with depth==0 -> erro, code 2;
//    DUP at depth==DEPTH -> code 1.
//  - Flags: zero = (result==0). SOMA: carry_out = bit WIDTH of sum, overflow = signed ovf.
//    SUB: carry_out = borrow (A<B unsigned), overflow = signed ovf.
//    Logic/NOT/DUP: carry_out=overflow=0. MUL: carry_out = (high half != 0), overflow=0.
//  - Flags and erro_codigo hold until replaced. Results wrap modulo 2^WIDTH.
// CONFIGURATION
//  RPN_MUL_EN defined: opcode 111 = MUL (single-cycle combinational multiply in CALCULA).
//  Not defined: opcode 111 rejected in OCIOSO, erro, code 3; no multiplier synthesised.
// STRUCTURE
//  rpn_pkg: opcode localparams (OP_SOMA..OP_MUL), FSM state encodings, erro_codigo constants.
//  Sub-module pilha_rpn (WIDTH, DEPTH): register-array stack with push/pop/replace/clear
//    ports; exposes topo, segundo, profundidade.
//  ALU and FSM stay inline in nucleo_rpn_param.
// TESTING (WIDTH=8, DEPTH=4)
//  - Push 0x05, 0x03; SOMA -> pronto at n+3, topo=0x08, profundidade=1, zero=0, carry=0.
//  - Push 0x80, 0x80; SOMA -> topo=0x00, zero=1, carry_out=1, overflow=1.
//  - Push 0x02, 0x05; SUB -> topo=0xFD, carry_out=1 (borrow), overflow=0.
//  - Push 4 values, 5th push -> erro pulse, code 1, depth stays 4; then limpar -> depth 0, topo 0.
//  - Empty stack, SOMA -> erro, code 2, no pronto; executar during ocupado -> erro, code 4.
//  - Opcode 111 on 0x10, 0x11: with RPN_MUL_EN -> topo=0x10, carry_out=1; without -> erro, code 3.

Source files
------------

// File: rtl/rpn_pkg.sv
// rpn_pkg
// Shared constants for the parametrised RPN core (nucleo_rpn_param) and its
// operand stack (pilha_rpn): opcodes, FSM state encoding, error cause codes,
// and a helper that classifies opcodes by how many stack operands they consume.
// Optional feature macro used by the core: RPN_MUL_EN (opcode 111 = MUL).
// No ports (package).
package rpn_pkg;

  // Opcodes carried on the 3-bit 'operacao' input
  localparam logic [2:0] OP_SOMA = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_DUP  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  // Control FSM states
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    BUSCA   = 2'd1,
    CALCULA = 2'd2,
    ESCREVE = 2'd3
  } estado_t;

  // Error causes reported on erro_codigo
  localparam logic [2:0] ERR_NENHUM  = 3'd0;
  localparam logic [2:0] ERR_CHEIA   = 3'd1;
  localparam logic [2:0] ERR_VAZIA   = 3'd2;
  localparam logic [2:0] ERR_ILEGAL  = 3'd3;
  localparam logic [2:0] ERR_OCUPADO = 3'd4;

  // Binary operations pop two operands and push one result
  function automatic logic ehBinario(input logic [2:0] op);
    return (op <= OP_XOR) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/pilha_rpn.sv
// pilha_rpn
// Register-array operand stack. Entry 0 is the bottom; the top lives at
// index profundidade-1. Only one update per cycle, chosen in this order:
// push, pop+replace (binary op result), replace (unary op result), pop.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   limpar_i            synchronous clear (empties the stack)
//   empilhar_i          push dado_i
//   desempilhar_i       pop one entry (with substituir_i: the new top is overwritten)
//   substituir_i        overwrite the current top with dado_i
//   dado_i              data for push/replace
//   topo_o, segundo_o   top and entry below top (0 when not present)
//   profundidade_o      current entry count
module pilha_rpn #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         limpar_i,
  input  logic                         empilhar_i,
  input  logic                         desempilhar_i,
  input  logic                         substituir_i,
  input  logic [WIDTH-1:0]             dado_i,
  output logic [WIDTH-1:0]             topo_o,
  output logic [WIDTH-1:0]             segundo_o,
  output logic [$clog2(DEPTH+1)-1:0]   profundidade_o
);

  localparam int PW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    profundidade_q, profundidade_d;
  logic             escreve;
  int               indiceEscrita;
  int               profInt;

  assign profInt = int'(profundidade_q);

  // Decide which slot (if any) gets written and how the depth moves.
  // The guards make impossible requests (push when full, pop when empty) no-ops.
  always_comb begin
    escreve        = 1'b0;
    indiceEscrita  = 0;
    profundidade_d = profundidade_q;
    if (empilhar_i && profInt < DEPTH) begin
      escreve        = 1'b1;
      indiceEscrita  = profInt;
      profundidade_d = profundidade_q + 1'b1;
    end else if (desempilhar_i && substituir_i && profInt >= 2) begin
      escreve        = 1'b1;
      indiceEscrita  = profInt - 2;
      profundidade_d = profundidade_q - 1'b1;
    end else if (substituir_i && profInt >= 1) begin
      escreve        = 1'b1;
      indiceEscrita  = profInt - 1;
    end else if (desempilhar_i && profInt >= 1) begin
      profundidade_d = profundidade_q - 1'b1;
    end
  end

  // Read-out mux: stale entries above the depth are never exposed.
  always_comb begin
    topo_o    = '0;
    segundo_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == profInt - 1) topo_o = mem_q[i];
      if (i == profInt - 2) segundo_o = mem_q[i];
    end
  end

  // Storage and depth register; clear wipes the array as well as the depth.
  always_ff @(posedge clk_i) begin
    if (reset_i || limpar_i) begin
      profundidade_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      profundidade_q <= profundidade_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (escreve && i == indiceEscrita) mem_q[i] <= dado_i;
      end
    end
  end

  assign profundidade_o = profundidade_q;

endmodule

// File: rtl/nucleo_rpn_param.sv
// nucleo_rpn_param
// Clocked RPN calculator core: operand stack (pilha_rpn), ALU and control FSM.
// A legal 'executar' walks OCIOSO -> BUSCA -> CALCULA -> ESCREVE -> OCIOSO;
// pronto and the new stack top appear together three clocks after the strobe
// is sampled. Rejected commands pulse erro for one cycle and latch the cause
// in erro_codigo.
// Optional feature macro: RPN_MUL_EN -- when defined, opcode 111 is a
// combinational WIDTHxWIDTH multiply (low half kept); when undefined,
// opcode 111 is rejected as illegal and no multiplier exists.
// Ports:
//   CLOCK_50, reset          clock, synchronous active-high reset
//   limpar                   clear stack and flags, abort any operation
//   empilhar, entrada        push strobe and operand
//   executar, operacao       operation strobe and opcode
//   ocupado, pronto          FSM busy, 1-cycle result-written pulse
//   topo, segundo            top of stack and entry below it
//   profundidade             entry count
//   zero, carry_out, overflow  flags of the last completed operation
//   erro, erro_codigo        1-cycle reject pulse and held cause
module nucleo_rpn_param
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        limpar,
  input  logic                        empilhar,
  input  logic [WIDTH-1:0]            entrada,
  input  logic                        executar,
  input  logic [2:0]                  operacao,
  output logic                        ocupado,
  output logic                        pronto,
  output logic [WIDTH-1:0]            topo,
  output logic [WIDTH-1:0]            segundo,
  output logic [$clog2(DEPTH+1)-1:0]  profundidade,
  output logic                        zero,
  output logic                        carry_out,
  output logic                        overflow,
  output logic                        erro,
  output logic [2:0]                  erro_codigo
);

  estado_t          estado_q, estado_d;
  logic [2:0]       opcode_q;
  logic [WIDTH-1:0] opA_q, opB_q, resultado_q;
  logic             zeroCalc_q, carryCalc_q, ovfCalc_q;
  logic             zero_q, carry_q, ovf_q;
  logic             pronto_q, pronto_d;
  logic             erro_q, erro_d;
  logic [2:0]       erroCodigo_q, erroCodigo_d;

  logic [2:0]       codigoPrecheck;
  logic             capturaOp;
  logic             pilhaEmpilha, pilhaDesempilha, pilhaSubstitui;
  logic [WIDTH-1:0] pilhaDado;
  logic [WIDTH-1:0] aluResultado;
  logic             aluCarry, aluOvf;
  logic [WIDTH:0]   somaExt, subExt;
`ifdef RPN_MUL_EN
  logic [2*WIDTH-1:0] produto;
`endif
  int               profInt;

  assign profInt = int'(profundidade);

  pilha_rpn #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) uPilha (
    .clk_i          (CLOCK_50),
    .reset_i        (reset),
    .limpar_i       (limpar),
    .empilhar_i     (pilhaEmpilha),
    .desempilhar_i  (pilhaDesempilha),
    .substituir_i   (pilhaSubstitui),
    .dado_i         (pilhaDado),
    .topo_o         (topo),
    .segundo_o      (segundo),
    .profundidade_o (profundidade)
  );

  // Operand-count check done in OCIOSO before an operation is accepted.
  // The illegal-opcode check is applied last so it wins over depth causes.
  always_comb begin
    codigoPrecheck = ERR_NENHUM;
    if (ehBinario(operacao)) begin
      if (profInt < 2) codigoPrecheck = ERR_VAZIA;
    end else begin
      if (profInt == 0) codigoPrecheck = ERR_VAZIA;
      else if (operacao == OP_DUP && profInt == DEPTH) codigoPrecheck = ERR_CHEIA;
    end
`ifndef RPN_MUL_EN
    if (operacao == OP_MUL) codigoPrecheck = ERR_ILEGAL;
`endif
  end

  // ALU on the operands registered in BUSCA (A = second, B = top).
  // Signed overflow: SOMA when operand signs match and the result sign differs;
  // SUB when operand signs differ and the result sign differs from A.
  always_comb begin
    somaExt = {1'b0, opA_q} + {1'b0, opB_q};
    subExt  = {1'b0, opA_q} - {1'b0, opB_q};
`ifdef RPN_MUL_EN
    produto = {{WIDTH{1'b0}}, opA_q} * {{WIDTH{1'b0}}, opB_q};
`endif
    aluResultado = '0;
    aluCarry     = 1'b0;
    aluOvf       = 1'b0;
    case (opcode_q)
      OP_SOMA: begin
        aluResultado = somaExt[WIDTH-1:0];
        aluCarry     = somaExt[WIDTH];
        aluOvf       = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) &&
                       (somaExt[WIDTH-1] != opA_q[WIDTH-1]);
      end
      OP_SUB: begin
        aluResultado = subExt[WIDTH-1:0];
        aluCarry     = subExt[WIDTH];
        aluOvf       = (opA_q[WIDTH-1] != opB_q[WIDTH-1]) &&
                       (subExt[WIDTH-1] != opA_q[WIDTH-1]);
      end
      OP_AND:  aluResultado = opA_q & opB_q;
      OP_OR:   aluResultado = opA_q | opB_q;
      OP_XOR:  aluResultado = opA_q ^ opB_q;
      OP_NOT:  aluResultado = ~opB_q;
      OP_DUP:  aluResultado = opB_q;
`ifdef RPN_MUL_EN
      OP_MUL: begin
        aluResultado = produto[WIDTH-1:0];
        aluCarry     = |produto[2*WIDTH-1:WIDTH];
      end
`endif
      default: aluResultado = '0;
    endcase
  end

  // Control FSM next state, command acceptance and stack commands.
  // limpar overrides everything; while busy, executar/empilhar are refused.
  always_comb begin
    estado_d        = estado_q;
    erro_d          = 1'b0;
    erroCodigo_d    = erroCodigo_q;
    pronto_d        = 1'b0;
    capturaOp       = 1'b0;
    pilhaEmpilha    = 1'b0;
    pilhaDesempilha = 1'b0;
    pilhaSubstitui  = 1'b0;
    pilhaDado       = entrada;
    if (limpar) begin
      estado_d = OCIOSO;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (executar) begin
            if (codigoPrecheck != ERR_NENHUM) begin
              erro_d       = 1'b1;
              erroCodigo_d = codigoPrecheck;
            end else begin
              capturaOp = 1'b1;
              estado_d  = BUSCA;
              if (empilhar) begin
                erro_d       = 1'b1;
                erroCodigo_d = ERR_OCUPADO;
              end
            end
          end else if (empilhar) begin
            if (profInt >= DEPTH) begin
              erro_d       = 1'b1;
              erroCodigo_d = ERR_CHEIA;
            end else begin
              pilhaEmpilha = 1'b1;
            end
          end
        end
        BUSCA:   estado_d = CALCULA;
        CALCULA: estado_d = ESCREVE;
        ESCREVE: begin
          estado_d  = OCIOSO;
          pronto_d  = 1'b1;
          pilhaDado = resultado_q;
          if (opcode_q == OP_DUP) begin
            pilhaEmpilha = 1'b1;
          end else if (opcode_q == OP_NOT) begin
            pilhaSubstitui = 1'b1;
          end else begin
            pilhaDesempilha = 1'b1;
            pilhaSubstitui  = 1'b1;
          end
        end
        default: estado_d = OCIOSO;
      endcase
      if (estado_q != OCIOSO && (executar || empilhar)) begin
        erro_d       = 1'b1;
        erroCodigo_d = ERR_OCUPADO;
      end
    end
  end

  // State, operand/result staging and output flag registers. Flags become
  // visible together with pronto, when the result lands on the stack.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      opcode_q     <= '0;
      opA_q        <= '0;
      opB_q        <= '0;
      resultado_q  <= '0;
      zeroCalc_q   <= 1'b0;
      carryCalc_q  <= 1'b0;
      ovfCalc_q    <= 1'b0;
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
      ovf_q        <= 1'b0;
      pronto_q     <= 1'b0;
      erro_q       <= 1'b0;
      erroCodigo_q <= ERR_NENHUM;
    end else begin
      estado_q     <= estado_d;
      pronto_q     <= pronto_d;
      erro_q       <= erro_d;
      erroCodigo_q <= erroCodigo_d;
      if (capturaOp) opcode_q <= operacao;
      if (estado_q == BUSCA) begin
        opA_q <= segundo;
        opB_q <= topo;
      end
      if (estado_q == CALCULA) begin
        resultado_q <= aluResultado;
        zeroCalc_q  <= (aluResultado == '0);
        carryCalc_q <= aluCarry;
        ovfCalc_q   <= aluOvf;
      end
      if (limpar) begin
        zero_q  <= 1'b0;
        carry_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (pronto_d) begin
        zero_q  <= zeroCalc_q;
        carry_q <= carryCalc_q;
        ovf_q   <= ovfCalc_q;
      end
    end
  end

  assign ocupado     = (estado_q != OCIOSO);
  assign pronto      = pronto_q;
  assign zero        = zero_q;
  assign carry_out   = carry_q;
  assign overflow    = ovf_q;
  assign erro        = erro_q;
  assign erro_codigo = erroCodigo_q;

endmodule

// File: tb/tb_nucleo_rpn_param.sv
// tb_nucleo_rpn_param
// Scoreboard bench for nucleo_rpn_param (WIDTH=8, DEPTH=4). Stimulus tasks
// predict pronto/erro events (with the cycle they must appear on) from a
// queue-based stack model; an independent monitor matches DUT events against
// that list. Idle-state outputs are compared against the model after each step.
// Honours RPN_MUL_EN the same way the design does.
module tb_nucleo_rpn_param;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int MASCARA = (1 << WIDTH) - 1;
  localparam int SMAX    = (1 << (WIDTH-1)) - 1;
  localparam int SMIN    = -(1 << (WIDTH-1));

  logic                       CLOCK_50 = 1'b0;
  logic                       reset    = 1'b1;
  logic                       limpar   = 1'b0;
  logic                       empilhar = 1'b0;
  logic [WIDTH-1:0]           entrada  = '0;
  logic                       executar = 1'b0;
  logic [2:0]                 operacao = '0;
  logic                       ocupado, pronto, zero, carry_out, overflow, erro;
  logic [WIDTH-1:0]           topo, segundo;
  logic [$clog2(DEPTH+1)-1:0] profundidade;
  logic [2:0]                 erro_codigo;

  nucleo_rpn_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .limpar       (limpar),
    .empilhar     (empilhar),
    .entrada      (entrada),
    .executar     (executar),
    .operacao     (operacao),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .topo         (topo),
    .segundo      (segundo),
    .profundidade (profundidade),
    .zero         (zero),
    .carry_out    (carry_out),
    .overflow     (overflow),
    .erro         (erro),
    .erro_codigo  (erro_codigo)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int ciclo;
    bit ehPronto;
    int codigo;
    int topo;
    int segundo;
    int prof;
    bit z;
    bit c;
    bit v;
  } evento_t;

  evento_t esperados[$];
  int      pilhaModelo[$];
  bit      zeroM = 1'b0, carryM = 1'b0, ovfM = 1'b0;
  int      codigoM = 0;
  int      ciclo = 0;
  int      erros = 0;
  int      checks = 0;

  always @(posedge CLOCK_50) ciclo <= ciclo + 1;

  function automatic int topoM();
    return (pilhaModelo.size() > 0) ? pilhaModelo[pilhaModelo.size()-1] : 0;
  endfunction

  function automatic int segundoM();
    return (pilhaModelo.size() > 1) ? pilhaModelo[pilhaModelo.size()-2] : 0;
  endfunction

  function automatic int comSinal(input int x);
    return (x > SMAX) ? x - (1 << WIDTH) : x;
  endfunction

  // Snapshot of the model as it should look when the event is presented
  function automatic evento_t novoEvento(input int c, input bit ehP, input int cod);
    evento_t e;
    e.ciclo = c; e.ehPronto = ehP; e.codigo = cod;
    e.topo = topoM(); e.segundo = segundoM(); e.prof = pilhaModelo.size();
    e.z = zeroM; e.c = carryM; e.v = ovfM;
    return e;
  endfunction

  function automatic int precheck(input int op);
    int n = pilhaModelo.size();
`ifndef RPN_MUL_EN
    if (op == 7) return 3;
`endif
    if (op <= 4 || op == 7) return (n < 2) ? 2 : 0;
    if (n == 0) return 2;
    if (op == 6 && n == DEPTH) return 1;
    return 0;
  endfunction

  // Arithmetic reference: plain integer maths, then wrap and derive flags
  task automatic calcula(input int op, input int a, input int b,
                         output int res, output bit cf, output bit vf);
    int s;
    cf = 1'b0; vf = 1'b0; res = 0;
    case (op)
      0: begin s = a + b; res = s & MASCARA; cf = (s > MASCARA);
               s = comSinal(a) + comSinal(b); vf = (s > SMAX) || (s < SMIN); end
      1: begin s = a - b; res = s & MASCARA; cf = (a < b);
               s = comSinal(a) - comSinal(b); vf = (s > SMAX) || (s < SMIN); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (~b) & MASCARA;
      6: res = b;
      default: begin s = a * b; res = s & MASCARA; cf = (s > MASCARA); end
    endcase
  endtask

  task automatic checkValor(input string nome, input int atual, input int esperado);
    checks++;
    if (atual != esperado) begin
      erros++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nome, atual, esperado, ciclo);
    end
  endtask

  task automatic checkOutput(input string ctx);
    checkValor({ctx, " topo"}, int'(topo), topoM());
    checkValor({ctx, " segundo"}, int'(segundo), segundoM());
    checkValor({ctx, " profundidade"}, int'(profundidade), pilhaModelo.size());
    checkValor({ctx, " zero"}, int'(zero), int'(zeroM));
    checkValor({ctx, " carry_out"}, int'(carry_out), int'(carryM));
    checkValor({ctx, " overflow"}, int'(overflow), int'(ovfM));
    checkValor({ctx, " erro_codigo"}, int'(erro_codigo), codigoM);
    checkValor({ctx, " ocupado"}, int'(ocupado), 0);
  endtask

  task automatic esperaOcioso(input string ctx);
    int k = 0;
    while (ocupado && k < 20) begin
      @(negedge CLOCK_50);
      k++;
    end
    checkValor({ctx, " busy timeout"}, int'(ocupado), 0);
  endtask

  // tipo 0 = push, 1 = execute, 2 = clear. comPush adds a simultaneous push
  // strobe; cutuca pokes a strobe one cycle into a legal operation.
  task automatic applyStimulus(input int tipo, input int valor, input int op,
                               input bit comPush, input bit cutuca);
    int c, cod, res;
    bit cf, vf;
    c = ciclo;
    if (tipo == 0) begin
      empilhar = 1'b1;
      entrada  = WIDTH'(valor);
      if (pilhaModelo.size() >= DEPTH) begin
        codigoM = 1;
        esperados.push_back(novoEvento(c + 1, 1'b0, 1));
      end else begin
        pilhaModelo.push_back(valor & MASCARA);
      end
      @(negedge CLOCK_50);
      empilhar = 1'b0;
    end else if (tipo == 1) begin
      executar = 1'b1;
      operacao = 3'(op);
      empilhar = comPush;
      entrada  = WIDTH'($urandom_range(0, MASCARA));
      cod = precheck(op);
      if (cod != 0) begin
        codigoM = cod;
        esperados.push_back(novoEvento(c + 1, 1'b0, cod));
      end else begin
        calcula(op, segundoM(), topoM(), res, cf, vf);
        if (comPush) begin
          codigoM = 4;
          esperados.push_back(novoEvento(c + 1, 1'b0, 4));
        end
        if (cutuca) begin
          codigoM = 4;
          esperados.push_back(novoEvento(c + 2, 1'b0, 4));
        end
        if (op <= 4 || op == 7) begin
          void'(pilhaModelo.pop_back());
          void'(pilhaModelo.pop_back());
        end else if (op == 5) begin
          void'(pilhaModelo.pop_back());
        end
        pilhaModelo.push_back(res);
        zeroM = (res == 0); carryM = cf; ovfM = vf;
        esperados.push_back(novoEvento(c + 4, 1'b1, 0));
      end
      @(negedge CLOCK_50);
      executar = 1'b0;
      empilhar = 1'b0;
      if (cod == 0 && cutuca) begin
        if ($urandom_range(0, 1) == 1) executar = 1'b1;
        else empilhar = 1'b1;
        operacao = 3'($urandom_range(0, 7));
        @(negedge CLOCK_50);
        executar = 1'b0;
        empilhar = 1'b0;
      end
      esperaOcioso("exec");
    end else begin
      limpar   = 1'b1;
      empilhar = comPush;
      pilhaModelo.delete();
      zeroM = 1'b0; carryM = 1'b0; ovfM = 1'b0;
      @(negedge CLOCK_50);
      limpar   = 1'b0;
      empilhar = 1'b0;
    end
  endtask

  function automatic int valorAleatorio();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 8'h80;
      2: return 8'hFF;
      3: return 8'h7F;
      default: return int'($urandom_range(0, MASCARA));
    endcase
  endfunction

  // Monitor: every pronto/erro pulse must match a predicted event at this cycle
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (!reset && (pronto || erro)) begin
        int idx;
        evento_t ev;
        idx = -1;
        if (pronto && erro) begin
          checks++;
          erros++;
          $display("[TB] FAIL event overlap: got pronto=1 erro=1, expected at most one (cycle %0d)", ciclo);
        end else begin
          for (int i = 0; i < esperados.size(); i++)
            if (idx < 0 && esperados[i].ciclo == ciclo && esperados[i].ehPronto == pronto) idx = i;
          checks++;
          if (idx < 0) begin
            erros++;
            $display("[TB] FAIL unexpected event: got %s at cycle %0d, expected none",
                     pronto ? "pronto" : "erro", ciclo);
          end else begin
            ev = esperados[idx];
            esperados.delete(idx);
            if (ev.ehPronto) begin
              checkValor("pronto topo", int'(topo), ev.topo);
              checkValor("pronto segundo", int'(segundo), ev.segundo);
              checkValor("pronto profundidade", int'(profundidade), ev.prof);
              checkValor("pronto zero", int'(zero), int'(ev.z));
              checkValor("pronto carry_out", int'(carry_out), int'(ev.c));
              checkValor("pronto overflow", int'(overflow), int'(ev.v));
            end else begin
              checkValor("erro codigo", int'(erro_codigo), ev.codigo);
              checkValor("erro topo", int'(topo), ev.topo);
              checkValor("erro profundidade", int'(profundidade), ev.prof);
            end
          end
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    checkOutput("reset");
    checkValor("reset pronto", int'(pronto), 0);
    checkValor("reset erro", int'(erro), 0);

    // 5 + 3
    applyStimulus(0, 8'h05, 0, 1'b0, 1'b0);
    applyStimulus(0, 8'h03, 0, 1'b0, 1'b0);
    applyStimulus(1, 0, 0, 1'b0, 1'b0);
    checkOutput("soma");
    checkValor("soma 5+3 topo", int'(topo), 8'h08);
    checkValor("soma 5+3 profundidade", int'(profundidade), 1);
    checkValor("soma 5+3 carry", int'(carry_out), 0);
    applyStimulus(2, 0, 0, 1'b0, 1'b0);

    // 0x80 + 0x80
    applyStimulus(0, 8'h80, 0, 1'b0, 1'b0);
    applyStimulus(0, 8'h80, 0, 1'b0, 1'b0);
    applyStimulus(1, 0, 0, 1'b0, 1'b0);
    checkValor("soma 80+80 topo", int'(topo), 0);
    checkValor("soma 80+80 zero", int'(zero), 1);
    checkValor("soma 80+80 carry", int'(carry_out), 1);
    checkValor("soma 80+80 overflow", int'(overflow), 1);
    applyStimulus(2, 0, 0, 1'b0, 1'b0);

    // 2 - 5
    applyStimulus(0, 8'h02, 0, 1'b0, 1'b0);
    applyStimulus(0, 8'h05, 0, 1'b0, 1'b0);
    applyStimulus(1, 0, 1, 1'b0, 1'b0);
    checkValor("sub 2-5 topo", int'(topo), 8'hFD);
    checkValor("sub 2-5 borrow", int'(carry_out), 1);
    checkValor("sub 2-5 overflow", int'(overflow), 0);
    applyStimulus(2, 0, 0, 1'b0, 1'b0);

    // Full stack, then clear
    for (int i = 0; i < 5; i++) applyStimulus(0, 8'h11 * (i + 1), 0, 1'b0, 1'b0);
    checkValor("cheia profundidade", int'(profundidade), 4);
    checkValor("cheia codigo", int'(erro_codigo), 1);
    applyStimulus(2, 0, 0, 1'b0, 1'b0);
    checkValor("limpar profundidade", int'(profundidade), 0);
    checkValor("limpar topo", int'(topo), 0);
    checkOutput("limpar");

    // Underflow, then strobe while busy
    applyStimulus(1, 0, 0, 1'b0, 1'b0);
    checkValor("vazia codigo", int'(erro_codigo), 2);
    applyStimulus(0, 8'h01, 0, 1'b0, 1'b0);
    applyStimulus(0, 8'h02, 0, 1'b0, 1'b0);
    applyStimulus(1, 0, 0, 1'b0, 1'b1);
    checkValor("ocupado codigo", int'(erro_codigo), 4);
    checkOutput("ocupado");
    applyStimulus(2, 0, 0, 1'b0, 1'b0);

    // Opcode 111
    applyStimulus(0, 8'h10, 0, 1'b0, 1'b0);
    applyStimulus(0, 8'h11, 0, 1'b0, 1'b0);
    applyStimulus(1, 0, 7, 1'b0, 1'b0);
`ifdef RPN_MUL_EN
    checkValor("mul topo", int'(topo), 8'h10);
    checkValor("mul carry", int'(carry_out), 1);
`else
    checkValor("mul ilegal codigo", int'(erro_codigo), 3);
    checkValor("mul ilegal profundidade", int'(profundidade), 2);
`endif
    checkOutput("op111");

    // Randomised command mix
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (r < 42)
        applyStimulus(0, valorAleatorio(), 0, 1'b0, 1'b0);
      else if (r < 92)
        applyStimulus(1, 0, $urandom_range(0, 7), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 7) == 0));
      else
        applyStimulus(2, 0, 0, ($urandom_range(0, 1) == 1), 1'b0);
      checkOutput("random");
    end

    repeat (6) @(negedge CLOCK_50);
    checkValor("pending events", esperados.size(), 0);
    foreach (esperados[i])
      $display("[TB] FAIL missing event: got none, expected %s at cycle %0d",
               esperados[i].ehPronto ? "pronto" : "erro", esperados[i].ciclo);

    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule
